obi_sram_arbiter: RTL and testbench
===================================

OBI_SRAM_ARBITER -- requirements
Module: obi_sram_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2: max accepted-but-unanswered transactions, 1..4.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 16: idle cycles before a held m1 lock is force-released, 1..255.
REQ-003 SHALL have clk_i, input, 1: single clock, all state on posedge.
REQ-004 SHALL have rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have m0_req_i / m1_req_i, input, 1: OBI request from core data port (m0) and SPI cache fill (m1).
REQ-006 SHALL have m0_gnt_o / m1_gnt_o, output, 1: OBI grant per master.
REQ-007 SHALL have m0_addr_i / m1_addr_i, input, 32: byte address.
REQ-008 SHALL have m0_we_i / m1_we_i, input, 1: write enable.
REQ-009 SHALL have m0_be_i / m1_be_i, input, 4: byte enables.
REQ-010 SHALL have m0_wdata_i / m1_wdata_i, input, 32: write data.
REQ-011 SHALL have m0_rvalid_o / m1_rvalid_o, output, 1: response valid per master.
REQ-012 SHALL have m0_rdata_o / m1_rdata_o, output, 32: response data.
REQ-013 SHALL have m1_lock_i, input, 1: m1 requests exclusive ownership beyond the current beat.
REQ-014 SHALL have s_req_o, s_gnt_i, s_addr_o[32], s_we_o, s_be_o[4], s_wdata_o[32], s_rvalid_i, s_rdata_i[32]: OBI manager port to the SRAM wrapper data port.
REQ-015 SHALL have s_illegal_i, input, 1: illegal-access flag from the SRAM wrapper, valid in the request cycle.
REQ-016 SHALL have err_valid_o (1), err_id_o (1), err_addr_o (32), outputs: sticky captured illegal access.
REQ-017 SHALL have err_clr_i, input, 1: clears error capture.

Function
REQ-018 SHALL compute selection combinationally: lock held -> m1 only; else single requester wins; both requesting -> master not granted last (round-robin).
REQ-019 SHALL drive s_req_o = (m0_req_i | m1_req_i) & ~full, and s_addr/we/be/wdata from the selected master; these are 0 when s_req_o=0.
REQ-020 SHALL assert mN_gnt_o only when N selected, s_req_o=1 and s_gnt_i=1; handshake = req & gnt.
REQ-021 SHALL push the granted master id into an in-order response FIFO (depth MAX_OUTSTANDING) on each handshake; full = count==MAX_OUTSTANDING, evaluated from registered count only (a same-cycle pop does not lift full).
REQ-022 SHALL, on s_rvalid_i with FIFO non-empty, pop the head and assert that master's rvalid_o in the same cycle; rdata_o of both masters = s_rdata_i; the other rvalid_o stays 0.
REQ-023 SHALL ignore s_rvalid_i when the FIFO is empty (no rvalid_o, no state change).
REQ-024 SHALL allow push and pop in the same cycle, count unchanged.
REQ-025 SHALL update last-grant register on every handshake to the granted id.
REQ-026 SHALL set lock on an m1 handshake with m1_lock_i=1 and clear it on an m1 handshake with m1_lock_i=0.
REQ-027 SHALL count consecutive cycles with lock held and m1_req_i=0; at LOCK_TIMEOUT, clear lock and counter; any m1_req_i resets counter.
REQ-028 SHALL, on a handshake with s_illegal_i=1 while err_valid_o=0, set err_valid_o and capture granted id and address; later errors do not overwrite.
REQ-029 SHALL clear err_valid_o on err_clr_i; a new illegal handshake in the same cycle wins (captured, err_valid_o stays 1).

Reset
REQ-030 SHALL, while rst_i=1 at a clock edge, set FIFO empty, lock 0, timeout counter 0, last-grant = m1 (m0 wins first tie), err_valid_o/err_id_o/err_addr_o = 0.
REQ-031 SHALL discard outstanding responses on reset mid-operation; s_rvalid_i after reset with empty FIFO is ignored per REQ-023.
REQ-032 SHALL hold all gnt_o/rvalid_o at 0 in any cycle rst_i=1.

Verification
REQ-033 Both masters request continuously, s_gnt_i=1, s_rvalid_i 1 cycle later -> grants alternate m0,m1,m0,...; each rvalid returns to the issuer with s_rdata_i.
REQ-034 m1 issues 4 beats with lock=1,1,1,0 while m0 requests -> m0 granted only after beat 4 handshake.
REQ-035 m1 handshake with lock=1 then m1_req_i=0 for 16 cycles, m0 requesting -> m0 granted in cycle 17, not earlier.
REQ-036 s_rvalid_i withheld, 3 back-to-back requests, MAX_OUTSTANDING=2 -> 2 handshakes, s_req_o=0 until first s_rvalid_i, third granted the cycle after.
REQ-037 m0 write addr 0x0000_1000 with s_illegal_i=1, then m1 illegal access -> err_valid_o=1, err_id_o=0, err_addr_o=0x0000_1000; err_clr_i -> err_valid_o=0.
REQ-038 rst_i pulsed with 2 outstanding, then s_rvalid_i=1 -> m0_rvalid_o=m1_rvalid_o=0, next tie grants m0.

Source files
------------

// File: rtl/obi_sram_arbiter.sv
// Two-master OBI arbiter in front of one SRAM data port: round-robin
// selection, m1 lock with idle timeout, in-order response routing, and
// sticky capture of the first illegal access.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   m0_* / m1_*            OBI subordinate ports (core data / SPI cache fill)
//   m1_lock_i              m1 asks to keep ownership after this beat
//   s_*                    OBI manager port towards the SRAM wrapper
//   s_illegal_i            wrapper flags the current request as illegal
//   err_valid_o/id/addr    first captured illegal access, cleared by err_clr_i
module obi_sram_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned LOCK_TIMEOUT    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    input  logic        m1_lock_i,
    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    input  logic        s_illegal_i,
    output logic        err_valid_o,
    output logic        err_id_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clr_i
);

    logic        lock_q;
    logic [7:0]  tmr_q;
    logic        last_q;
    logic [3:0]  fifo_q;
    logic [1:0]  wr_q;
    logic [1:0]  rd_q;
    logic [2:0]  cnt_q;
    logic        err_valid_q;
    logic        err_id_q;
    logic [31:0] err_addr_q;

    logic        sel;
    logic        sel_req;
    logic        full;
    logic        hs;
    logic        pop;
    logic        head;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // While locked only m1 may issue; m0 requests must not open a
    // transaction on m1's behalf, so the request is gated by m1_req_i.
    always_comb begin
        sel     = m1_req_i;
        sel_req = m0_req_i | m1_req_i;
        if (lock_q) begin
            sel     = 1'b1;
            sel_req = m1_req_i;
        end else if (m0_req_i && m1_req_i) begin
            sel = ~last_q;
        end
    end

    // Full comes from the registered count only: a pop this cycle does
    // not make room until the next one.
    assign full = (cnt_q == 3'(MAX_OUTSTANDING));
    assign hs   = s_req_o & s_gnt_i;
    assign pop  = s_rvalid_i & (cnt_q != 3'd0) & ~rst_i;
    assign head = fifo_q[rd_q];

    always_comb begin
        s_req_o   = sel_req & ~full & ~rst_i;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (s_req_o) begin
            s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
            s_we_o    = sel ? m1_we_i    : m0_we_i;
            s_be_o    = sel ? m1_be_i    : m0_be_i;
            s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign m0_gnt_o    = hs & ~sel;
    assign m1_gnt_o    = hs & sel;
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_valid_o = err_valid_q;
    assign err_id_o    = err_id_q;
    assign err_addr_o  = err_addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q      <= 1'b0;
            tmr_q       <= '0;
            last_q      <= 1'b1;
            fifo_q      <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            err_valid_q <= 1'b0;
            err_id_q    <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            if (hs) begin
                fifo_q[wr_q] <= sel;
                wr_q         <= nxt(wr_q);
                last_q       <= sel;
            end
            if (pop) begin
                rd_q <= nxt(rd_q);
            end
            unique case ({hs, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase

            if (hs && sel) begin
                lock_q <= m1_lock_i;
                tmr_q  <= '0;
            end else if (lock_q && !m1_req_i) begin
                if (tmr_q == 8'(LOCK_TIMEOUT - 1)) begin
                    lock_q <= 1'b0;
                    tmr_q  <= '0;
                end else begin
                    tmr_q <= tmr_q + 8'd1;
                end
            end else begin
                tmr_q <= '0;
            end

            // A fresh illegal handshake beats a simultaneous clear.
            if (hs && s_illegal_i && (!err_valid_q || err_clr_i)) begin
                err_valid_q <= 1'b1;
                err_id_q    <= sel;
                err_addr_q  <= s_addr_o;
            end else if (err_clr_i) begin
                err_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_obi_sram_arbiter.sv
// Self-checking bench for obi_sram_arbiter: directed scenarios followed
// by random traffic, all checked against a queue-based reference model.
module tb_obi_sram_arbiter;

    localparam int MAXO = 2;
    localparam int LTO  = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m1_lock_i;
    logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, s_illegal_i;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [3:0]  s_be_o;
    logic        err_valid_o, err_id_o, err_clr_i;
    logic [31:0] err_addr_o;

    obi_sram_arbiter #(.MAX_OUTSTANDING(MAXO), .LOCK_TIMEOUT(LTO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i),
        .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i),
        .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i),
        .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .m1_lock_i(m1_lock_i),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o),
        .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .s_illegal_i(s_illegal_i),
        .err_valid_o(err_valid_o), .err_id_o(err_id_o),
        .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    int          q[$];
    bit          lock_m  = 1'b0;
    int          idle_m  = 0;
    bit          last_m  = 1'b1;
    bit          errv_m  = 1'b0;
    bit          errid_m = 1'b0;
    logic [31:0] erra_m  = '0;

    // Model outcome and DUT samples of the latest cycle.
    bit   m_hs, m_sel;
    logic o_g0, o_g1, o_req, o_rv0, o_rv1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        bit          sel, req, hs, pop, hd;
        logic [31:0] ea;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        @(negedge clk_i);
        if (lock_m) sel = 1'b1;
        else if (m0_req_i && m1_req_i) sel = !last_m;
        else sel = m1_req_i;
        req = !rst_i && (q.size() < MAXO) &&
              (lock_m ? m1_req_i : (m0_req_i || m1_req_i));
        hs  = req && s_gnt_i;
        pop = !rst_i && s_rvalid_i && (q.size() > 0);
        hd  = pop ? (q[0] == 1) : 1'b0;
        ea  = !req ? 32'd0 : (sel ? m1_addr_i : m0_addr_i);
        ewe = req && (sel ? m1_we_i : m0_we_i);
        ebe = !req ? 4'd0 : (sel ? m1_be_i : m0_be_i);
        ewd = !req ? 32'd0 : (sel ? m1_wdata_i : m0_wdata_i);
        chk("s_req", 32'(s_req_o), 32'(req));
        chk("s_addr", s_addr_o, ea);
        chk("s_we", 32'(s_we_o), 32'(ewe));
        chk("s_be", 32'(s_be_o), 32'(ebe));
        chk("s_wdata", s_wdata_o, ewd);
        chk("m0_gnt", 32'(m0_gnt_o), 32'(hs && !sel));
        chk("m1_gnt", 32'(m1_gnt_o), 32'(hs && sel));
        chk("m0_rvalid", 32'(m0_rvalid_o), 32'(pop && !hd));
        chk("m1_rvalid", 32'(m1_rvalid_o), 32'(pop && hd));
        chk("m0_rdata", m0_rdata_o, s_rdata_i);
        chk("m1_rdata", m1_rdata_o, s_rdata_i);
        chk("err_valid", 32'(err_valid_o), 32'(errv_m));
        chk("err_id", 32'(err_id_o), 32'(errid_m));
        chk("err_addr", err_addr_o, erra_m);
        o_g0 = m0_gnt_o; o_g1 = m1_gnt_o; o_req = s_req_o;
        o_rv0 = m0_rvalid_o; o_rv1 = m1_rvalid_o;
        m_hs = hs; m_sel = sel;
        @(posedge clk_i);
        if (rst_i) begin
            q.delete();
            lock_m = 1'b0; idle_m = 0; last_m = 1'b1;
            errv_m = 1'b0; errid_m = 1'b0; erra_m = '0;
        end else begin
            if (pop) void'(q.pop_front());
            if (hs) begin
                q.push_back(int'(sel));
                last_m = sel;
            end
            if (hs && sel) begin
                lock_m = m1_lock_i;
                idle_m = 0;
            end else if (lock_m && !m1_req_i) begin
                idle_m++;
                if (idle_m == LTO) begin
                    lock_m = 1'b0;
                    idle_m = 0;
                end
            end else begin
                idle_m = 0;
            end
            if (hs && s_illegal_i && (!errv_m || err_clr_i)) begin
                errv_m = 1'b1; errid_m = sel;
                erra_m = sel ? m1_addr_i : m0_addr_i;
            end else if (err_clr_i) begin
                errv_m = 1'b0;
            end
        end
        #1;
    endtask

    task automatic rnd_payload();
        m0_addr_i  = $urandom; m1_addr_i  = $urandom;
        m0_wdata_i = $urandom; m1_wdata_i = $urandom;
        m0_we_i    = 1'($urandom); m1_we_i = 1'($urandom);
        m0_be_i    = 4'($urandom); m1_be_i = 4'($urandom);
        s_rdata_i  = $urandom;
    endtask

    initial begin
        int beats, n;
        rst_i = 1'b1; err_clr_i = 1'b0; s_illegal_i = 1'b0;
        m1_lock_i = 1'b0; s_gnt_i = 1'b1; s_rvalid_i = 1'b1;
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        rnd_payload();

        // Requests and responses during reset must stay silent.
        repeat (2) cyc();
        chk("rst_err_valid", 32'(err_valid_o), 32'd0);

        // Both masters streaming: alternating grants, m0 first.
        rst_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rnd_payload();
            cyc();
            if (i < 2) chk("rr_order", {o_g1, o_g0}, (i == 0) ? 2'b01 : 2'b10);
        end

        // m1 locked burst of 4 beats; m0 waits for the last one.
        beats = 0;
        n = 0;
        while (beats < 4 && n < 20) begin
            m1_lock_i = (beats < 3);
            rnd_payload();
            cyc();
            if (beats > 0) chk("lock_m0_held", 32'(o_g0), 32'd0);
            if (m_hs && m_sel) beats++;
            n++;
        end
        chk("lock_beats", beats, 4);
        m1_lock_i = 1'b0;
        cyc();
        chk("lock_m0_after", 32'(o_g0), 32'd1);

        // Lock idle timeout.
        m0_req_i = 1'b0; m1_req_i = 1'b1; m1_lock_i = 1'b1;
        cyc();
        chk("to_m1_hs", 32'(o_g1), 32'd1);
        m1_req_i = 1'b0; m1_lock_i = 1'b0; m0_req_i = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            rnd_payload();
            cyc();
            chk("to_m0_gnt", 32'(o_g0), 32'(i == 17));
        end

        // Outstanding limit with responses withheld.
        m0_req_i = 1'b0; s_rvalid_i = 1'b1;
        repeat (3) cyc();
        m0_req_i = 1'b1; s_rvalid_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_rvalid_i = (i == 4);
            rnd_payload();
            cyc();
            chk("full_req", 32'(o_req), 32'(i < 2 || i == 5));
        end
        m0_req_i = 1'b0; s_rvalid_i = 1'b1;
        repeat (3) cyc();

        // First illegal access sticks; clear drops it.
        m0_req_i = 1'b1; m0_addr_i = 32'h0000_1000; m0_we_i = 1'b1;
        s_illegal_i = 1'b1;
        cyc();
        m0_req_i = 1'b0; m1_req_i = 1'b1; m1_addr_i = 32'h0000_2000;
        cyc();
        m1_req_i = 1'b0; s_illegal_i = 1'b0;
        cyc();
        chk("err_v", 32'(err_valid_o), 32'd1);
        chk("err_id0", 32'(err_id_o), 32'd0);
        chk("err_a", err_addr_o, 32'h0000_1000);
        err_clr_i = 1'b1;
        cyc();
        err_clr_i = 1'b0;
        cyc();
        chk("err_clr", 32'(err_valid_o), 32'd0);

        // Reset with two outstanding responses.
        m0_req_i = 1'b1; m1_req_i = 1'b1; s_rvalid_i = 1'b0;
        repeat (2) cyc();
        m0_req_i = 1'b0; m1_req_i = 1'b0; rst_i = 1'b1;
        cyc();
        rst_i = 1'b0; s_rvalid_i = 1'b1;
        cyc();
        chk("rst_drop", {o_rv1, o_rv0}, 2'b00);
        m0_req_i = 1'b1; m1_req_i = 1'b1;
        cyc();
        chk("rst_tie_m0", 32'(o_g0), 32'd1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst_i       = ($urandom_range(63) == 0);
            m0_req_i    = 1'($urandom);
            m1_req_i    = ($urandom_range(3) != 0);
            m1_lock_i   = 1'($urandom);
            s_gnt_i     = ($urandom_range(3) != 0);
            s_rvalid_i  = 1'($urandom);
            s_illegal_i = ($urandom_range(7) == 0);
            err_clr_i   = ($urandom_range(15) == 0);
            rnd_payload();
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
